if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 169 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues one word fetch at a time to instruction
// memory and buffers returned {pc, instruction} pairs in a small FIFO that
// the decode stage drains through a valid/ready handshake. A redirect from
// decode flushes the FIFO, retargets the fetch PC and discards any reply
// still in flight.
module if_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  // IDLE: nothing outstanding; WAIT: one request whose data will be kept;
  // DROP: one request whose data must be thrown away (redirected meanwhile).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] fpc_reg, fpc_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic              outstanding;
  logic              not_full;
  logic              has_data;
  logic              idle_issue;
  logic              push_en;
  logic              pop_en;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] redirect_pc;
  logic              redirect_lsb_unused;

  // Redirect targets are forced to a word boundary; the low bits are dropped.
  assign redirect_pc         = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_addr[1:0];

  assign outstanding = (state_reg == ST_WAIT) || (state_reg == ST_DROP);
  assign not_full    = (count_reg != FULL_CNT);
  assign has_data    = (count_reg != '0);

  // A new fetch may only start with nothing in flight, no stall, no redirect
  // and room in the queue for its reply.
  assign idle_issue = (state_reg == ST_IDLE) && !stall && !redirect_valid && not_full;

  // Memory request: held for the whole life of an outstanding request.
  assign mem_req  = !rst && (outstanding || idle_issue);
  assign mem_addr = rst ? '0 : (outstanding ? req_addr_reg : fpc_reg);

  // Replies are kept either for a zero-latency ack in the issue cycle or for
  // a normal ack in WAIT; a redirect in the ack cycle discards the data.
  assign push_en   = !rst && mem_ack && !redirect_valid &&
                     (idle_issue || (state_reg == ST_WAIT));
  assign push_addr = outstanding ? req_addr_reg : fpc_reg;

  // Output handshake: a redirect hides the head entry in its cycle.
  assign out_valid = !rst && has_data && !redirect_valid;
  assign pop_en    = out_valid && out_ready;
  assign out_pc    = (rst || !has_data) ? '0 : pc_mem[rd_ptr_reg];
  assign out_inst  = (rst || !has_data) ? '0 : inst_mem[rd_ptr_reg];

  // Fetch sequencing: next state, fetch PC and address of the request in flight.
  always_comb begin
    state_next    = state_reg;
    fpc_next      = fpc_reg;
    req_addr_next = req_addr_reg;
    if (redirect_valid) begin
      fpc_next = redirect_pc;
      case (state_reg)
        ST_WAIT: state_next = mem_ack ? ST_IDLE : ST_DROP;
        ST_DROP: state_next = mem_ack ? ST_IDLE : ST_DROP;
        default: state_next = ST_IDLE;
      endcase
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (idle_issue) begin
            fpc_next      = fpc_reg + PC_STEP;
            req_addr_next = fpc_reg;
            // A zero-latency ack finishes the request in its issue cycle.
            state_next    = mem_ack ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT, ST_DROP: begin
          if (mem_ack) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Queue bookkeeping: pointers wrap naturally, count tracks occupancy.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      fpc_reg      <= RESET_PC;
      req_addr_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fpc_reg      <= fpc_next;
      req_addr_reg <= req_addr_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_ptr_reg]   <= push_addr;
      inst_mem[wr_ptr_reg] <= mem_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a table of directed vectors, hand-written
// multi-cycle sequences, then a randomized run, all also checked every cycle
// against a queue-based reference model of the fetch unit.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  if_prefetch_queue #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc   = 32'h0;
  logic [31:0] m_paddr = 32'h0;
  bit          m_pend  = 1'b0;
  bit          m_keep  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit st, input bit rd, input logic [31:0] ra,
                        input bit ack, input logic [31:0] d, input bit rdy);
    rst            = r;
    stall          = st;
    redirect_valid = rd;
    redirect_addr  = ra;
    mem_ack        = ack;
    mem_data       = d;
    out_ready      = rdy;
  endtask

  // Compare the DUT against the model halfway through the cycle.
  task automatic at_neg();
    bit          e_req;
    bit          e_ov;
    logic [31:0] e_addr;
    @(negedge clk);
    e_req  = !rst && (m_pend || (!stall && !redirect_valid && mq.size() < DEPTH));
    e_addr = m_pend ? m_paddr : m_fpc;
    e_ov   = !rst && (mq.size() != 0) && !redirect_valid;
    check("mdl_mem_req", mem_req, e_req);
    if (e_req) check("mdl_mem_addr", mem_addr, e_addr);
    check("mdl_out_valid", out_valid, e_ov);
    if (e_ov) begin
      check("mdl_out_pc", out_pc, mq[0].pc);
      check("mdl_out_inst", out_inst, mq[0].inst);
    end
    if (rst) begin
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_inst", out_inst, 32'h0);
    end
  endtask

  // Clock edge: advance the model using the inputs that were just sampled.
  task automatic tick();
    bit   issue;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_fpc  = 32'h0;
      m_pend = 1'b0;
      m_keep = 1'b0;
    end else begin
      issue = !m_pend && !stall && !redirect_valid && (mq.size() < DEPTH);
      if (!redirect_valid && mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        m_fpc = {redirect_addr[31:2], 2'b00};
        if (m_pend) begin
          if (mem_ack) m_pend = 1'b0;
          else m_keep = 1'b0;
        end
      end else if (m_pend) begin
        if (mem_ack) begin
          if (m_keep) begin
            e.pc = m_paddr; e.inst = mem_data;
            mq.push_back(e);
          end
          m_pend = 1'b0;
        end
      end else if (issue) begin
        if (mem_ack) begin
          e.pc = m_fpc; e.inst = mem_data;
          mq.push_back(e);
        end else begin
          m_pend  = 1'b1;
          m_keep  = 1'b1;
          m_paddr = m_fpc;
        end
        m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] ra,
                      input bit ack, input logic [31:0] d, input bit rdy);
    set_in(r, st, rd, ra, ack, d, rdy);
    at_neg();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0); tick();
    step(1, 0, 0, 0, 1, 0, 1); tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, st, rd;
    logic [31:0] ra;
    bit          ack;
    logic [31:0] d;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  function automatic vec_t mk(bit r, bit st, bit rd, logic [31:0] ra, bit ack, logic [31:0] d,
                              bit rdy, bit e_req, logic [31:0] e_addr, bit e_ov,
                              logic [31:0] e_pc, logic [31:0] e_inst);
    vec_t v;
    v.r = r; v.st = st; v.rd = rd; v.ra = ra; v.ack = ack; v.d = d; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst  st rd raddr        ack data          rdy | req addr         ov pc      inst
    vt[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,        0, 32'h0,   32'h0);
    vt[1]  = mk(0, 0, 0, 32'h0,   1, 32'hA0000000, 1,   1, 32'h0,        0, 32'h0,   32'h0);
    vt[2]  = mk(0, 0, 0, 32'h0,   1, 32'hA0000001, 1,   1, 32'h4,        1, 32'h0,   32'hA0000000);
    vt[3]  = mk(0, 0, 0, 32'h0,   1, 32'hA0000002, 1,   1, 32'h8,        1, 32'h4,   32'hA0000001);
    vt[4]  = mk(0, 0, 0, 32'h0,   1, 32'hA0000003, 1,   1, 32'hC,        1, 32'h8,   32'hA0000002);
    vt[5]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h10,       1, 32'hC,   32'hA0000003);
    vt[6]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1,   1, 32'h10,       0, 32'h0,   32'h0);
    vt[7]  = mk(0, 0, 0, 32'h0,   1, 32'hA0000004, 1,   1, 32'h10,       0, 32'h0,   32'h0);
    vt[8]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   1, 32'h14,       1, 32'h10,  32'hA0000004);
    vt[9]  = mk(0, 0, 1, 32'h203, 0, 32'h0,        1,   1, 32'h14,       0, 32'h0,   32'h0);
    vt[10] = mk(0, 0, 0, 32'h0,   1, 32'hA0000005, 1,   1, 32'h14,       0, 32'h0,   32'h0);
    vt[11] = mk(0, 0, 0, 32'h0,   1, 32'hA0000006, 1,   1, 32'h200,      0, 32'h0,   32'h0);
    vt[12] = mk(0, 1, 0, 32'h0,   0, 32'h0,        1,   0, 32'h0,        1, 32'h200, 32'hA0000006);

    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].st, vt[i].rd, vt[i].ra, vt[i].ack, vt[i].d, vt[i].rdy);
      $display("vec %0d: req=%0b addr=%0h ov=%0b pc=%0h inst=%0h", i, mem_req, mem_addr,
               out_valid, out_pc, out_inst);
      check($sformatf("vec%0d_mem_req", i), mem_req, vt[i].e_req);
      if (vt[i].e_req) check($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
      if (vt[i].e_ov) begin
        check($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
        check($sformatf("vec%0d_out_inst", i), out_inst, vt[i].e_inst);
      end
      tick();
    end

    // Fill to full with decode blocked; issue must resume right after a pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 32'hB0000000 + i, 0);
      check("full_fill_req", mem_req, 1'b1);
      check("full_fill_addr", mem_addr, 32'(i * 4));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 32'hBAD0BAD0, 0);
      check("full_req_blocked", mem_req, 1'b0);
      check("full_head_pc", out_pc, 32'h0);
      tick();
    end
    step(0, 0, 0, 0, 0, 0, 1);
    check("full_pop_cycle_req", mem_req, 1'b0);
    check("full_pop_valid", out_valid, 1'b1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0);
    check("full_resume_req", mem_req, 1'b1);
    check("full_resume_addr", mem_addr, 32'h10);
    check("full_resume_head", out_pc, 32'h4);
    tick();
    $display("seq full: resumed fetch at 0x10");

    // Redirect while waiting on 0x8; the late ack must be discarded.
    do_reset();
    step(0, 0, 0, 0, 1, 32'hC0000000, 1); tick();
    step(0, 0, 0, 0, 1, 32'hC0000001, 1); tick();
    step(0, 0, 0, 0, 0, 0, 1);
    check("drop_wait_addr", mem_addr, 32'h8);
    tick();
    step(0, 0, 1, 32'h100, 0, 0, 1);
    check("drop_redir_ov", out_valid, 1'b0);
    check("drop_redir_hold_addr", mem_addr, 32'h8);
    tick();
    step(0, 0, 0, 0, 0, 0, 1);
    check("drop_hold_req", mem_req, 1'b1);
    check("drop_hold_addr", mem_addr, 32'h8);
    tick();
    step(0, 0, 0, 0, 0, 0, 1); tick();
    step(0, 0, 0, 0, 1, 32'hDEADDEAD, 1);
    check("drop_ack_addr", mem_addr, 32'h8);
    tick();
    step(0, 0, 0, 0, 1, 32'hBEEFBEEF, 0);
    check("drop_next_req", mem_req, 1'b1);
    check("drop_next_addr", mem_addr, 32'h100);
    check("drop_discarded", out_valid, 1'b0);
    tick();
    step(0, 1, 0, 0, 0, 0, 1);
    check("drop_first_valid", out_valid, 1'b1);
    check("drop_first_pc", out_pc, 32'h100);
    check("drop_first_inst", out_inst, 32'hBEEFBEEF);
    tick();
    $display("seq drop: first pc after redirect %0h", 32'h100);

    // Redirect to an unaligned target with two entries queued.
    do_reset();
    step(0, 0, 0, 0, 1, 32'hD0000000, 0); tick();
    step(0, 0, 0, 0, 1, 32'hD0000001, 0); tick();
    step(0, 1, 0, 0, 0, 0, 0);
    check("flush_pre_valid", out_valid, 1'b1);
    tick();
    step(0, 0, 1, 32'h203, 0, 0, 1);
    check("flush_redir_ov", out_valid, 1'b0);
    check("flush_redir_req", mem_req, 1'b0);
    tick();
    step(0, 0, 0, 0, 0, 0, 1);
    check("flush_empty", out_valid, 1'b0);
    check("flush_next_req", mem_req, 1'b1);
    check("flush_next_addr", mem_addr, 32'h200);
    tick();
    $display("seq flush: refetch at 0x200");

    // Stall in IDLE: no issue, but queued entries still drain.
    do_reset();
    step(0, 0, 0, 0, 1, 32'hE0000000, 0); tick();
    step(0, 0, 0, 0, 1, 32'hE0000001, 0); tick();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 1);
      check("stall_req", mem_req, 1'b0);
      check("stall_ov", out_valid, (i < 2) ? 1'b1 : 1'b0);
      if (i < 2) check("stall_drain_pc", out_pc, 32'(i * 4));
      tick();
    end
    step(0, 0, 0, 0, 0, 0, 1);
    check("stall_release_req", mem_req, 1'b1);
    check("stall_release_addr", mem_addr, 32'h8);
    tick();
    $display("seq stall: drained 2 entries, fetch resumes at 0x8");

    // Fetch PC wrap at the top of the address space.
    do_reset();
    step(0, 0, 1, 32'hFFFFFFFE, 0, 0, 1); tick();
    step(0, 0, 0, 0, 1, 32'hF0000000, 1);
    check("wrap_top_addr", mem_addr, 32'hFFFFFFFC);
    tick();
    step(0, 0, 0, 0, 0, 0, 0);
    check("wrap_next_req", mem_req, 1'b1);
    check("wrap_next_addr", mem_addr, 32'h0);
    check("wrap_head_pc", out_pc, 32'hFFFFFFFC);
    tick();
    $display("seq wrap: fetch address wrapped to 0");

    // Reset mid-request, then a stray ack in IDLE must be ignored.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 0, 0, 0, 1, 32'h12345678, 1);
    check("rstmid_req", mem_req, 1'b0);
    check("rstmid_ov", out_valid, 1'b0);
    tick();
    step(0, 1, 0, 0, 1, 32'h87654321, 1);
    check("rstlate_req", mem_req, 1'b0);
    tick();
    step(0, 0, 0, 0, 0, 0, 1);
    check("rstlate_ignored", out_valid, 1'b0);
    check("rst_first_addr", mem_addr, 32'h0);
    check("rst_first_req", mem_req, 1'b1);
    tick();
    $display("seq reset: first fetch after reset at 0x0");

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0),
           (($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7) : $urandom),
           $urandom_range(0, 1),
           $urandom,
           ($urandom_range(0, 3) != 0));
      tick();
    end
    $display("random phase: 4000 cycles applied");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
